// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer
// Serialises one LANES x 8-bit vector store or load over a byte-wide memory
// port, one lane per cycle, then pulses resp_valid for one cycle.
// Lane 1 is the most significant byte of req_data / resp_data.
// Optional feature macro: VSEQ_LANE_MASK_EN adds a per-lane enable mask
// (req_mask, bit LANES-1 = lane 1). A masked-off lane still takes its cycle
// but issues no access, and loads return 0x00 for it.
//
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, and requests
// presented while it is low are dropped, not queued. resp_valid is a
// single-cycle pulse with no back-pressure.
module vector_mem_sequencer #(
  parameter int ADDR_W = 12,
  parameter int LANES  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_base,
  input  logic [8*LANES-1:0]   req_data,
`ifdef VSEQ_LANE_MASK_EN
  input  logic [LANES-1:0]     req_mask,
`endif
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 resp_valid,
  output logic [8*LANES-1:0]   resp_data,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STORE = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   i;
  logic [IDX_W-1:0]   i_nxt;
  logic [IDX_W-1:0]   i_prev;
  logic [ADDR_W-1:0]  base_q;
  logic [8*LANES-1:0] data_q;
  logic [8*LANES-1:0] load_buf;
  logic [LANES-1:0]   mask_q;
  logic [LANES-1:0]   mask_in;

`ifdef VSEQ_LANE_MASK_EN
  assign mask_in = req_mask;
`else
  assign mask_in = '1;
`endif

  assign i_nxt     = i + IDX_W'(1);
  assign i_prev    = i - IDX_W'(1);
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Bit position of a 0-based lane index (lane 1 sits in the top slot).
  function automatic logic [IDX_W-1:0] lane_pos(input logic [IDX_W-1:0] idx);
    return LAST - idx;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [8*LANES-1:0] v,
                                           input logic [IDX_W-1:0]   idx);
    return v[{lane_pos(idx), 3'b000} +: 8];
  endfunction

  function automatic logic lane_on(input logic [LANES-1:0] m,
                                   input logic [IDX_W-1:0] idx);
    return m[lane_pos(idx)];
  endfunction

  // Address wraps naturally at 2^ADDR_W because the sum keeps ADDR_W bits.
  function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [IDX_W-1:0]  idx);
    return b + ADDR_W'(idx);
  endfunction

  // Sequencer FSM: all memory-port and response outputs are registered here,
  // so the access for lane i appears the cycle after it is scheduled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      i          <= '0;
      base_q     <= '0;
      data_q     <= '0;
      load_buf   <= '0;
      mask_q     <= '1;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            base_q    <= req_base;
            data_q    <= req_data;
            mask_q    <= mask_in;
            load_buf  <= '0;
            i         <= '0;
            mem_en    <= lane_on(mask_in, '0);
            mem_we    <= req_write;
            mem_addr  <= req_base;
            mem_wdata <= lane_byte(req_data, '0);
            state     <= req_write ? S_STORE : S_LOAD;
          end
        end
        S_STORE, S_LOAD: begin
          // Read data for lane i-1 arrives one cycle after its strobe.
          if (state == S_LOAD && i != '0) begin
            load_buf[{lane_pos(i_prev), 3'b000} +: 8] <=
              lane_on(mask_q, i_prev) ? mem_rdata : 8'h00;
          end
          if (i == LAST) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (state == S_STORE) begin
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            i         <= i_nxt;
            mem_en    <= lane_on(mask_q, i_nxt);
            mem_addr  <= lane_addr(base_q, i_nxt);
            mem_wdata <= lane_byte(data_q, i_nxt);
          end
        end
        S_DRAIN: begin
          // Last lane's read data is merged straight into the response.
          resp_data  <= {load_buf[8*LANES-1:8],
                         lane_on(mask_q, LAST) ? mem_rdata : 8'h00};
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          i     <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

Sequences one 128-bit, 16-lane vector transfer between the vector datapath and the byte-wide data memory port. Every store or load is fully serialised one byte per cycle, and the block raises a one-cycle completion pulse at the end. It sits between the execute/memory stage (packed lane results plus base address) and the 8-bit data memory. It also drives `busy` so the pipeline stalls while a transfer is in flight.

## Interface
- `ADDR_W`, 12, memory address width.
- `LANES`, 16, number of 8-bit lanes; vector width is 8*LANES.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  transfer request.
- `req_ready`  out  1  block can accept a request (high only in IDLE).
- `req_write`  in  1  1 = vector store, 0 = vector load.
- `req_base`  in  ADDR_W  base byte address.
- `req_data`  in  8*LANES  store payload; lane 1 in bits [127:120], lane 16 in [7:0].
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  write enable, qualified by `mem_en`.
- `mem_addr`  out  ADDR_W  memory byte address.
- `mem_wdata`  out  8  write byte.
- `mem_rdata`  in  8  read byte, valid the cycle after a read strobe.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_data`  out  8*LANES  loaded vector, same lane packing as `req_data`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **States:**
  - IDLE, STORE, LOAD, DRAIN, RESP.
  - A 4-bit lane counter `i` counts 0..LANES-1.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch `req_base`, `req_data` and `req_write`, clear `i`.
  - Go to STORE if `req_write`=1, else LOAD.
  - Requests while not ready are ignored (not queued).
- **STORE:**
  - Each cycle drive `mem_en`=1, `mem_we`=1, `mem_addr`=base+i, `mem_wdata`=lane i+1.
  - After lane 16 go to RESP.
- **LOAD:**
  - Each cycle drive `mem_en`=1, `mem_we`=0, `mem_addr`=base+i.
  - `mem_rdata` from read i is captured into lane i+1 of the load buffer in the following cycle.
  - After issuing lane 16 go to DRAIN.
- **DRAIN:** capture lane 16, no memory access, go to RESP.
- **RESP:**
  - `resp_valid`=1 for exactly one cycle, then IDLE.
  - Load: `resp_data` = assembled buffer.
  - Store: `resp_data` keeps its previous value.
- **Address arithmetic:** base+i is computed modulo 2^ADDR_W. Base 0xFF8 therefore writes 0xFF8..0xFFF then 0x000..0x007.
- **Output hold:** `resp_data` holds until the next load completes.
- **Reset:**
  - State goes to IDLE, `i`=0.
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `resp_valid`=0, `resp_data`=0, `busy`=0.
  - `req_ready`=1 in the first cycle after reset.
  - Reset mid-transfer aborts it. Bytes already written stay written, and no `resp_valid` is issued.

## Timing
- Memory outputs are registered. The accept edge is cycle 0 and the first access appears in cycle 1.
- **Store:** accesses in cycles 1..16, `resp_valid` in cycle 17, `req_ready` high again in cycle 18.
- **Load:** reads in cycles 1..16, DRAIN in cycle 17, `resp_valid` and `resp_data` valid in cycle 18, `req_ready` in cycle 19.
- Back-to-back requests: earliest next accept is cycle 18 (store) or 19 (load).
- `mem_en` is never high in IDLE, DRAIN or RESP.
- `req_valid` high during RESP is not accepted until IDLE.

## Configuration
- **`VSEQ_LANE_MASK_EN` defined:**
  - Adds input `req_mask` [LANES-1:0], latched at accept; bit LANES-1 is lane 1.
  - A masked-off lane still consumes its cycle, so timing is unchanged, but `mem_en`=0 in that cycle.
  - On load, a masked-off lane returns 0x00.
- **`VSEQ_LANE_MASK_EN` undefined:** the port is absent and all lanes are always active.

## Test plan
- **Reset, then idle:**
  - Stimulus: reset, then `req_valid`=0 for 5 cycles.
  - Response: `req_ready`=1, `busy`=0, `mem_en`=0, `resp_data`=0.
- **Store:**
  - Stimulus: base 0x100, `req_data`=0x00112233_44556677_8899AABB_CCDDEEFF.
  - Response: cycles 1..16 write 0x00..0xFF to 0x100..0x10F in order; `resp_valid` pulse in cycle 17 only.
- **Load:**
  - Stimulus: memory holds 0x10..0x1F at 0x200..0x20F; load base 0x200.
  - Response: `resp_data`=0x10111213_..._1C1D1E1F in cycle 18; `mem_we`=0 throughout.
- **Wrap-around:** store at base 0xFFA writes 0xFFA..0xFFF then 0x000..0x009.
- **Reset mid-store:**
  - Stimulus: assert `rst` at cycle 6 of a store.
  - Response: writes stop after lane 5, no `resp_valid`, `req_ready`=1 the next cycle, next request served normally.
- **Mask (macro on):**
  - Stimulus: `req_mask`=0xFF00, store.
  - Response: `mem_en` only in cycles 1..8, `resp_valid` still in cycle 17; masked load returns 0x00 in lanes 9..16.
